// File: rtl/mdu_pkg.sv
// MDU op encodings, controller state encoding and default latencies.
// MADD/MADDU/MSUB/MSUBU count as start ops only when MDU_MADD_EN is defined.
package mdu_pkg;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_start_op(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit {hi,lo} result generator; zero latency, no flow control.
// Divide by zero returns the current {hi,lo}; MADD family only under MDU_MADD_EN.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] rt_mag_safe;
  logic [31:0] rt_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic        div_zero;

  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // Signed divide on magnitudes: 0x80000000 is its own unsigned magnitude,
  // so 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
  assign rs_mag      = rs[31] ? (~rs + 32'd1) : rs;
  assign rt_mag      = rt[31] ? (~rt + 32'd1) : rt;
  assign div_zero    = (rt == 32'd0);
  assign rt_mag_safe = div_zero ? 32'd1 : rt_mag;
  assign rt_safe     = div_zero ? 32'd1 : rt;
  assign q_mag       = rs_mag / rt_mag_safe;
  assign r_mag       = rs_mag % rt_mag_safe;
  assign quo_s       = (rs[31] ^ rt[31]) ? (~q_mag + 32'd1) : q_mag;
  assign rem_s       = rs[31] ? (~r_mag + 32'd1) : r_mag;
  assign quo_u       = rs / rt_safe;
  assign rem_u       = rs % rt_safe;

  always_comb begin
    res = {hi, lo};
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   if (!div_zero) res = {rem_s, quo_s};
      OP_DIVU:  if (!div_zero) res = {rem_u, quo_u};
`ifdef MDU_MADD_EN
      OP_MADD:  res = {hi, lo} + prod_s;
      OP_MADDU: res = {hi, lo} + prod_u;
      OP_MSUB:  res = {hi, lo} - prod_s;
      OP_MSUBU: res = {hi, lo} - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: result computed at acceptance, committed to HI/LO after MULT/DIV_CYCLES busy.
// Ops arriving while busy are ignored (stall unit holds them off); MDU_MADD_EN adds MADD family.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        cancel,
  input  logic        mf_sel,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      shadow_q, shadow_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      arith_res;
  logic             accept;

  mdu_arith u_arith (
    .op  (op),
    .rs  (rs_data),
    .rt  (rt_data),
    .hi  (hi_q),
    .lo  (lo_q),
    .res (arith_res)
  );

  assign start   = op_valid && is_start_op(op);
  assign accept  = (state_q == S_IDLE) && op_valid && !cancel;
  assign busy    = (state_q == S_RUN);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = mf_sel ? hi_q : lo_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_start_op(op)) begin
            shadow_d = arith_res;
            cnt_d    = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_d  = S_RUN;
          end else if (op == OP_MTHI) begin
            hi_d = rs_data;
          end else if (op == OP_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      S_RUN: begin
        // An abort wins over a commit landing on the same edge.
        if (cancel) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_ONE) begin
          {hi_d, lo_d} = shadow_q;
          cnt_d        = '0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: cycle-level behavioural model plus directed literal pins.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        cancel;
  logic        mf_sel;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .cancel   (cancel),
    .mf_sel   (mf_sel),
    .start    (start),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .rd_data  (rd_data)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;
  logic [63:0] m_res  = 64'd0;
  int          m_left = 0;   // busy cycles still to come

  function automatic bit tb_is_start(input logic [3:0] o);
    case (o)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] model_res(input logic [3:0] o, input logic [31:0] a, b, h, l);
    longint          sa, sb;
    longint unsigned ua, ub, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {h, l};
    case (o)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return ua * ub;
      OP_DIV:   if (b == 32'd0) return acc; else return {32'(sa % sb), 32'(sa / sb)};
      OP_DIVU:  if (b == 32'd0) return acc; else return {32'(ua % ub), 32'(ua / ub)};
      OP_MADD:  return acc + 64'(sa * sb);
      OP_MADDU: return acc + ua * ub;
      OP_MSUB:  return acc - 64'(sa * sb);
      OP_MSUBU: return acc - ua * ub;
      default:  return acc;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_res = 64'd0; m_left = 0;
    end else if (m_left > 0) begin
      if (cancel) m_left = 0;
      else if (m_left == 1) begin
        {m_hi, m_lo} = m_res;
        m_left = 0;
      end else m_left = m_left - 1;
    end else if (op_valid && !cancel) begin
      if (tb_is_start(op)) begin
        m_res  = model_res(op, rs_data, rt_data, m_hi, m_lo);
        m_left = (op == OP_DIV || op == OP_DIVU) ? DC : MC;
      end else if (op == OP_MTHI) m_hi = rs_data;
      else if (op == OP_MTLO) m_lo = rs_data;
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  string       pin_name;
  logic [3:0]  pin_m;      // [0] busy, [1] start, [2] hi/lo, [3] rd_data
  logic        pin_busy, pin_start;
  logic [31:0] pin_hi, pin_lo, pin_rd;
  int          pin_seq  = 0;
  int          pin_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("start", 32'(start), 32'(op_valid && tb_is_start(op)));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("rd_data", rd_data, mf_sel ? m_hi : m_lo);
      if (pin_seq != pin_seen) begin
        if (pin_m[0]) chk({pin_name, ".busy"}, 32'(busy), 32'(pin_busy));
        if (pin_m[1]) chk({pin_name, ".start"}, 32'(start), 32'(pin_start));
        if (pin_m[2]) begin
          chk({pin_name, ".hi"}, hi, pin_hi);
          chk({pin_name, ".lo"}, lo, pin_lo);
        end
        if (pin_m[3]) chk({pin_name, ".rd"}, rd_data, pin_rd);
        pin_seen = pin_seq;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pin(input string nm, input logic [3:0] m, input logic b, input logic s,
                     input logic [31:0] h, input logic [31:0] l, input logic [31:0] r);
    pin_name = nm; pin_m = m; pin_busy = b; pin_start = s;
    pin_hi = h; pin_lo = l; pin_rd = r;
    pin_seq = pin_seq + 1;
  endtask

  // Called at posedge+1; applies inputs for one cycle and returns at the next posedge+1.
  task automatic cyc(input logic v, input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic c);
    op_valid = v; op = o; rs_data = a; rt_data = b; cancel = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] oh,
                        input logic [31:0] ol, input logic [31:0] eh, input logic [31:0] el);
    pin({nm, "_acc"}, 4'b0111, 1'b0, 1'b1, oh, ol, 32'd0);
    cyc(1'b1, o, a, b, 1'b0);
    for (int i = 0; i < n; i++) begin
      pin({nm, "_busy"}, 4'b0101, 1'b1, 1'b0, oh, ol, 32'd0);
      idle();
    end
    pin({nm, "_res"}, 4'b0101, 1'b0, 1'b0, eh, el, 32'd0);
    idle();
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b0; op_valid = 1'b0; op = 4'd0; rs_data = 32'd0; rt_data = 32'd0;
    cancel = 1'b0; mf_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b1;
    chk_on = 1'b1;
    pin("reset", 4'b1111, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    idle();

    run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, MC, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", OP_DIVU, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           32'h0000_0001, 32'h7FFF_FFFC);

    pin("mthi_acc", 4'b0111, 1'b0, 1'b0, 32'd1, 32'h7FFF_FFFC, 32'd0);
    cyc(1'b1, OP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    pin("mtlo_acc", 4'b0111, 1'b0, 1'b0, 32'h1234_5678, 32'h7FFF_FFFC, 32'd0);
    cyc(1'b1, OP_MTLO, 32'hCAFE_BABE, 32'd0, 1'b0);
    mf_sel = 1'b1;
    pin("mf_hi", 4'b1101, 1'b0, 1'b0, 32'h1234_5678, 32'hCAFE_BABE, 32'h1234_5678);
    idle();
    mf_sel = 1'b0;
    pin("mf_lo", 4'b1101, 1'b0, 1'b0, 32'h1234_5678, 32'hCAFE_BABE, 32'hCAFE_BABE);
    idle();

    cyc(1'b1, OP_MTHI, 32'hAAAA_0000, 32'd0, 1'b0);
    cyc(1'b1, OP_MTLO, 32'h0000_BBBB, 32'd0, 1'b0);
    run_op("div0", OP_DIV, 32'h0000_1234, 32'd0, DC, 32'hAAAA_0000, 32'h0000_BBBB,
           32'hAAAA_0000, 32'h0000_BBBB);

    pin("cxl_acc", 4'b0011, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
    cyc(1'b1, OP_MULT, 32'd7, 32'd9, 1'b0);
    for (int i = 0; i < 2; i++) begin
      pin("cxl_busy", 4'b0001, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
      idle();
    end
    pin("cxl_cyc", 4'b0101, 1'b1, 1'b0, 32'hAAAA_0000, 32'h0000_BBBB, 32'd0);
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    run_op("multu_post_cxl", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC,
           32'hAAAA_0000, 32'h0000_BBBB, 32'hFFFF_FFFE, 32'h0000_0001);

    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'hFFFF_FFFE, 32'h0000_0001,
           32'h0000_0000, 32'h8000_0000);

    pin("idle_cxl", 4'b0011, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
    cyc(1'b1, OP_MULT, 32'd3, 32'd3, 1'b1);
    pin("idle_cxl_next", 4'b0101, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 32'd0);
    idle();

    cyc(1'b1, OP_MTHI, 32'd0, 32'd0, 1'b0);
    cyc(1'b1, OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
    run_op("maddu", OP_MADDU, 32'd1, 32'd1, MC, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
`else
    pin("maddu_off", 4'b0111, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'd0);
    cyc(1'b1, OP_MADDU, 32'd1, 32'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pin("maddu_off_after", 4'b0101, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'd0);
      idle();
    end
`endif

    cyc(1'b1, OP_MULT, 32'd5, 32'd5, 1'b0);
    idle();
    idle();
    reset = 1'b0;
    pin("rst_midrun", 4'b0101, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    idle();
    reset = 1'b1;
    for (int i = 0; i < MC + 1; i++) begin
      pin("rst_no_commit", 4'b0101, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
      idle();
    end

    for (int k = 0; k < 4000; k++) begin
      mf_sel = 1'($urandom_range(0, 1));
      if (m_left > 0)
        cyc(1'b0, 4'($urandom_range(0, 15)), rnd32(), rnd32(), ($urandom_range(0, 15) == 0));
      else
        cyc(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), rnd32(), rnd32(),
            ($urandom_range(0, 7) == 0));
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
